hazard_controller: RTL

Pipeline hazard and stall controller for the 5-stage MIPS datapath. It sits beside the IF/ID and ID/EX pipeline registers and generates their hold and bubble controls plus PC write-enable. It resolves three hazard classes:
- load-use data hazards;
- branch operand hazards (branches resolve in ID);
- multi-cycle HI/LO (mult/div) structural occupancy.

It also keeps a saturating count of stall cycles for performance measurement.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/hazard_match.sv | 18 +
 rtl/hazard_controller.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package pipeline_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 32;

endpackage : pipeline_pkg

// File: rtl/hazard_match.sv
// Compares one producer destination against the ID instruction's used source registers.
module hazard_match
    import pipeline_pkg::*;
(
    input  logic [4:0] dest_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       uses_rs_i,
    input  logic       uses_rt_i,
    output logic       match_o
);

    // $0 is hardwired to zero, so a write to it can never create a dependency.
    assign match_o = (dest_i != REG_ZERO) &&
                     ((uses_rs_i && (rs_i == dest_i)) ||
                      (uses_rt_i && (rt_i == dest_i)));

endmodule : hazard_match

// File: rtl/hazard_controller.sv
// Load-use, branch-operand and HI/LO occupancy stall control for the 5-stage MIPS pipeline,
// with a saturating stall-cycle counter.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LAT     = 4,
    parameter int STALL_CNT_BITS = STALL_CNT_W
)
(
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [4:0]             IDrs,
    input  logic [4:0]             IDrt,
    input  logic                   IDUsesRs,
    input  logic                   IDUsesRt,
    input  logic                   IDBranch,
    input  logic                   IDReadHILO,
    input  logic                   IDWriteHILO,
    input  logic                   BranchTaken,
    input  logic                   EXMemRead,
    input  logic                   EXRegWrite,
    input  logic [4:0]             EXDest,
    input  logic                   MEMMemRead,
    input  logic [4:0]             MEMDest,
    output logic                   PCWrite,
    output logic                   IFIDStall,
    output logic                   IFIDFlush,
    output logic                   IDEXFlush,
    output logic                   MDBusy,
    output logic [STALL_CNT_W-1:0] StallCycles
);

    md_state_e                 state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [STALL_CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_match, mem_match;
    logic load_use, br_haz, md_haz, stall;

    hazard_match u_ex_match (
        .dest_i    (EXDest),
        .rs_i      (IDrs),
        .rt_i      (IDrt),
        .uses_rs_i (IDUsesRs),
        .uses_rt_i (IDUsesRt),
        .match_o   (ex_match)
    );

    hazard_match u_mem_match (
        .dest_i    (MEMDest),
        .rs_i      (IDrs),
        .rt_i      (IDrt),
        .uses_rs_i (IDUsesRs),
        .uses_rt_i (IDUsesRt),
        .match_o   (mem_match)
    );

    assign load_use = EXMemRead && ex_match;
    assign br_haz   = IDBranch && ((EXRegWrite && ex_match) || (MEMMemRead && mem_match));
    assign md_haz   = (state_q == MD_BUSY) && (IDReadHILO || IDWriteHILO);
    assign stall    = load_use || br_haz || md_haz;

    // Reset forces the pipeline to free-run; a stalled branch never flushes so it can re-resolve.
    assign PCWrite     = Rst || !stall;
    assign IFIDStall   = !Rst && stall;
    assign IDEXFlush   = !Rst && stall;
    assign IFIDFlush   = !Rst && BranchTaken && !stall;
    assign MDBusy      = !Rst && (state_q == MD_BUSY);
    assign StallCycles = STALL_CNT_W'(stall_cnt_q);

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        case (state_q)
            RUN: begin
                if (IDWriteHILO && !stall) begin
                    state_d = MD_BUSY;
                    cnt_d   = 4'(MULDIV_LAT);
                end
            end
            MD_BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule : hazard_controller
